// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage (port A) and a long-latency result port (port B). Port B
// results wait in a small FIFO and drain in idle port-A cycles. A starvation
// timer stalls port A when the FIFO head has been losing for too long.
// Optional performance counters are enabled with `define WB_ARB_PERF_EN.
module wb_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_wen,
  input  logic [ADDR_WIDTH-1:0]        a_rd,
  input  logic [DATA_WIDTH-1:0]        a_data,
  output logic                         a_stall,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [ADDR_WIDTH-1:0]        b_rd,
  input  logic [DATA_WIDTH-1:0]        b_data,
  input  logic [ADDR_WIDTH-1:0]        q_rs1,
  input  logic [ADDR_WIDTH-1:0]        q_rs2,
  output logic                         q_hit1,
  output logic                         q_hit2,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]       fifo_cnt
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_conflict_cnt,
  output logic [31:0]                  perf_stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Starvation timer counts down from the limit; zero means the head is owed a slot.
  localparam logic [3:0] STARVE_INIT = 4'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] mem_rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
  logic [PW-1:0]         ent_off    [DEPTH];
  logic [DEPTH-1:0]      ent_valid;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            starve_left_q, starve_left_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic a_req, head_avail, full, starved, enq, head_win, a_win;

  // Arbitration decision for this cycle.
  always_comb begin
    a_req      = a_wen && (a_rd != '0);
    head_avail = (cnt_q != '0);
    full       = (cnt_q == CW'(DEPTH));
    starved    = (starve_left_q == '0);
    b_ready    = !full;
    enq        = b_valid && !full && (b_rd != '0);
    head_win   = head_avail && (starved || !a_req);
    a_win      = a_req && !(starved && head_avail);
    a_stall    = a_req && starved && head_avail;
  end

  // FIFO, timer and write-port next-state.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (enq) begin
      mem_rd_d[wr_ptr_q]   = b_rd;
      mem_data_d[wr_ptr_q] = b_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (head_win) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(enq) - CW'(head_win);

    // Only a losing, non-empty head burns time; A never wins while the timer is at zero.
    if (head_avail && !head_win) begin
      starve_left_d = starve_left_q - 4'd1;
    end else begin
      starve_left_d = STARVE_INIT;
    end

    rf_wen_d   = a_win || head_win;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (a_win) begin
      rf_waddr_d = a_rd;
      rf_wdata_d = a_data;
    end else if (head_win) begin
      rf_waddr_d = mem_rd_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end
  end

  // Hazard query against live FIFO entries plus the enqueue in flight.
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_off[i]   = PW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, ent_off[i]} < cnt_q);
      if (ent_valid[i] && (mem_rd_q[i] == q_rs1)) q_hit1 = 1'b1;
      if (ent_valid[i] && (mem_rd_q[i] == q_rs2)) q_hit2 = 1'b1;
    end
    if (enq && (b_rd == q_rs1)) q_hit1 = 1'b1;
    if (enq && (b_rd == q_rs2)) q_hit2 = 1'b1;
    q_hit1 = q_hit1 && (q_rs1 != '0);
    q_hit2 = q_hit2 && (q_rs2 != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      starve_left_q <= STARVE_INIT;
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
    end else begin
      mem_rd_q      <= mem_rd_d;
      mem_data_q    <= mem_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      starve_left_q <= starve_left_d;
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign fifo_cnt = cnt_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d, perf_stall_q, perf_stall_d;

  // Free-running event counters, wrapping on overflow.
  always_comb begin
    perf_conflict_d = perf_conflict_q + 32'(a_req && head_avail);
    perf_stall_d    = perf_stall_q + 32'(a_stall);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_conflict_cnt = perf_conflict_q;
  assign perf_stall_cnt    = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_wen;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_hit1, q_hit2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_cnt;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_stall_cnt;
`endif

  wb_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_wen    (a_wen),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .a_stall  (a_stall),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd     (b_rd),
    .b_data   (b_data),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_hit1   (q_hit1),
    .q_hit2   (q_hit2),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .fifo_cnt (fifo_cnt)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        a_wen;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        x_stall;
    logic        x_bready;
    logic [1:0]  x_cnt;
    logic        x_hit1;
    logic        x_hit2;
    logic        x_wen;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_exp_t;

  vec_t    tbl[$];
  rf_exp_t sb[$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: compare the write produced by the previous vector, drive this one,
  // check the combinational outputs, and queue the write it should produce.
  task automatic apply(input vec_t v, input string tag);
    rf_exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " rf_wen"}, 32'(rf_wen), 32'(e.wen));
      if (e.wen) begin
        chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
        chk({tag, " rf_wdata"}, rf_wdata, e.data);
      end
    end
    rst     = v.rst;
    a_wen   = v.a_wen;
    a_rd    = v.a_rd;
    a_data  = v.a_data;
    b_valid = v.b_valid;
    b_rd    = v.b_rd;
    b_data  = v.b_data;
    q_rs1   = v.q1;
    q_rs2   = v.q2;
    #1;
    chk({tag, " a_stall"},  32'(a_stall),  32'(v.x_stall));
    chk({tag, " b_ready"},  32'(b_ready),  32'(v.x_bready));
    chk({tag, " fifo_cnt"}, 32'(fifo_cnt), 32'(v.x_cnt));
    chk({tag, " q_hit1"},   32'(q_hit1),   32'(v.x_hit1));
    chk({tag, " q_hit2"},   32'(q_hit2),   32'(v.x_hit2));
    sb.push_back('{v.x_wen, v.x_addr, v.x_data});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst a  ard adata    bv brd bdata     q1 q2  stl rdy cnt h1 h2  wen adr wdata
    for (int i = 0; i < 5; i++)
      tbl.push_back('{0, 0, 0, 0,       0, 0, 0,        0, 0,  0, 1, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{0, 1, 5, 'h1234,    0, 0, 0,        0, 0,  0, 1, 0, 0, 0,  1, 5, 'h1234});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        0, 0,  0, 1, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,         1, 7, 'hCAFE,   7, 3,  0, 1, 0, 1, 0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        7, 0,  0, 1, 1, 1, 0,  1, 7, 'hCAFE});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        7, 0,  0, 1, 0, 0, 0,  0, 0, 0});
    // fill the FIFO while A writes every cycle, then the forced drain
    tbl.push_back('{0, 1, 3, 'hA0,      1, 1, 'hB1,     1, 2,  0, 1, 0, 1, 0,  1, 3, 'hA0});
    tbl.push_back('{0, 1, 3, 'hA1,      1, 2, 'hB2,     1, 2,  0, 1, 1, 1, 1,  1, 3, 'hA1});
    tbl.push_back('{0, 1, 3, 'hA2,      1, 4, 'hB4,     4, 2,  0, 0, 2, 0, 1,  1, 3, 'hA2});
    tbl.push_back('{0, 1, 3, 'hA3,      1, 4, 'hB4,     1, 2,  0, 0, 2, 1, 1,  1, 3, 'hA3});
    tbl.push_back('{0, 1, 3, 'hA4,      1, 4, 'hB4,     0, 0,  0, 0, 2, 0, 0,  1, 3, 'hA4});
    tbl.push_back('{0, 1, 3, 'hA5,      1, 4, 'hB4,     1, 4,  1, 0, 2, 1, 0,  1, 1, 'hB1});
    tbl.push_back('{0, 1, 3, 'hA5,      1, 4, 'hB4,     4, 1,  0, 1, 1, 1, 0,  1, 3, 'hA5});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        2, 4,  0, 0, 2, 1, 1,  1, 2, 'hB2});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        2, 4,  0, 1, 1, 0, 1,  1, 4, 'hB4});
    // x0 on both ports
    tbl.push_back('{0, 1, 0, 'hFF,      1, 0, 'hEE,     0, 0,  0, 1, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        0, 0,  0, 1, 0, 0, 0,  0, 0, 0});
    // simultaneous enqueue and dequeue
    tbl.push_back('{0, 0, 0, 0,         1, 9, 'h99,     9, 0,  0, 1, 0, 1, 0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,         1, 10, 'hAA,    9, 10, 0, 1, 1, 1, 1,  1, 9, 'h99});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        10, 9, 0, 1, 1, 1, 0,  1, 10, 'hAA});
    tbl.push_back('{0, 0, 0, 0,         0, 0, 0,        0, 0,  0, 1, 0, 0, 0,  0, 0, 0});

    rst = 1'b1; a_wen = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0; q_rs1 = '0; q_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rf_wen",   32'(rf_wen),   32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata", rf_wdata,      32'd0);
    chk("reset a_stall",  32'(a_stall),  32'd0);
    chk("reset b_ready",  32'(b_ready),  32'd1);
    chk("reset fifo_cnt", 32'(fifo_cnt), 32'd0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Reset with two entries queued: they must vanish and rf must clear.
    apply('{0, 1, 3, 'hC0, 1, 11, 'hD1, 11, 0,  0, 1, 0, 1, 0, 1, 3, 'hC0}, "r1");
    apply('{0, 1, 3, 'hC1, 1, 12, 'hD2, 11, 12, 0, 1, 1, 1, 1, 1, 3, 'hC1}, "r2");
    apply('{1, 1, 3, 'hC2, 0, 0, 0,     11, 12, 0, 0, 2, 1, 1, 0, 0, 0},    "r3");
    apply('{0, 0, 0, 0,    0, 0, 0,     11, 12, 0, 1, 0, 0, 0, 0, 0, 0},    "r4");
    chk("post-reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("post-reset rf_wdata", rf_wdata,      32'd0);

    apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}, "tail");
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      rf_exp_t e;
      e = sb.pop_front();
      chk("flush rf_wen", 32'(rf_wen), 32'(e.wen));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage (port A);
  - a long-latency unit such as mul/div or an outstanding load (port B).
- Port B results are queued in a small FIFO and drained in idle port cycles.
- A starvation guard forces a drain by stalling port A.
- A query port exposes pending destination registers to the hazard unit.
- Sits between the writeback stage and the register file.

Parameters:
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width.
- DEPTH, 2, port B FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose arbitration before port A is stalled; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- a_wen  in  1  port A write request.
- a_rd  in  ADDR_WIDTH  port A destination.
- a_data  in  DATA_WIDTH  port A data.
- a_stall  out  1  port A not accepted this cycle; WB must hold its inputs.
- b_valid  in  1  port B result valid.
- b_ready  out  1  port B can accept.
- b_rd  in  ADDR_WIDTH  port B destination.
- b_data  in  DATA_WIDTH  port B data.
- q_rs1  in  ADDR_WIDTH  hazard query address 1.
- q_rs2  in  ADDR_WIDTH  hazard query address 2.
- q_hit1  out  1  q_rs1 matches a queued entry, or the incoming B write this cycle.
- q_hit2  out  1  same, for q_rs2.
- rf_wen  out  1  register-file write enable; registered.
- rf_waddr  out  ADDR_WIDTH  register-file write address; registered.
- rf_wdata  out  DATA_WIDTH  register-file write data; registered.
- fifo_cnt  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: FIFO emptied, pointers 0, starve counter 0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0, a_stall=0, b_ready=1, fifo_cnt=0.
- Writes to x0:
  - Port A with a_rd==0 is accepted (a_stall=0) but consumes no port slot.
  - Port B with b_rd==0 is handshaken (b_valid&&b_ready) but not enqueued.
- Enqueue: b_valid&&b_ready&&b_rd!=0 writes {b_rd,b_data} at the tail.
- b_ready=!full, with no same-cycle dequeue bypass. When full, b_ready=0 even if a drain occurs that cycle.
- Arbitration each cycle. Let A_req=a_wen&&a_rd!=0, H=FIFO non-empty, F=starve counter==STARVE_LIMIT.
  - F&&H: head wins; a_stall=A_req.
  - A_req, otherwise: A wins; a_stall=0; if H, starve counter +1.
  - H, otherwise: head wins; starve counter reset to 0.
  - Neither: no write.
  - Starve counter also resets to 0 whenever the head wins or the FIFO is empty. It saturates at STARVE_LIMIT.
- Write timing: the winner is presented on rf_* at the next posedge, giving 1-cycle latency. rf_wen=0 in cycles with no winner; rf_waddr/rf_wdata then hold their previous values.
- Simultaneous enqueue and dequeue (not full) leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- A stalled port A has priority over the head again once the counter is cleared. No two consecutive forced drains occur unless port A stays idle.
- Query: q_hitN=1 when q_rsN!=0 and it matches b_rd of any valid entry, or the current accepted enqueue. Purely combinational.
- The hazard unit, not this block, resolves WAW ordering between A and queued B entries.
- Reset mid-operation discards all queued entries. rf_wen is 0 on the cycle after reset is sampled.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- When defined, adds two 32-bit outputs, reset to 0 and wrapping on overflow:
  - perf_conflict_cnt: increments each cycle A_req&&H.
  - perf_stall_cnt: increments each cycle a_stall=1.
- When undefined, neither port nor either counter exists.

Test Plan:
- Reset then idle → rf_wen=0, b_ready=1, fifo_cnt=0, a_stall=0 for 5 cycles.
- A only: a_wen=1, a_rd=5, a_data=0x1234 for one cycle → next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234.
- B only: enqueue {rd=7, 0xCAFE} → fifo_cnt=1 for one cycle. Next cycle rf_wen=1, rf_waddr=7, rf_wdata=0xCAFE; fifo_cnt returns to 0. q_hit1=1 for q_rs1=7 in the enqueue cycle.
- Full FIFO: enqueue rd=1 then rd=2 while a_wen=1 (rd=3) every cycle → b_ready=0 once full, fifo_cnt=2.
  - Third b_valid is not accepted.
  - After STARVE_LIMIT=4 losing cycles, a_stall=1 for one cycle and rf_waddr=1 is written. The next cycle A wins.
- x0 handling: a_rd=0 and an accepted b_rd=0 in the same cycle → rf_wen=0 next cycle, fifo_cnt stays 0, a_stall=0.
- Reset asserted with 2 entries queued → next cycle fifo_cnt=0, rf_wen=0, b_ready=1, q_hit1=0 for the previously queued rd.
